// File: rtl/mux_ext_pkg.sv
// Shared constants for the extending select pipeline: extension mode
// encodings and the skid-buffer occupancy states.
package mux_ext_pkg;

  localparam logic [1:0] MODE_NATIVE = 2'b00;
  localparam logic [1:0] MODE_ZEXT8  = 2'b01;
  localparam logic [1:0] MODE_SEXT8  = 2'b10;
  localparam logic [1:0] MODE_SEXT16 = 2'b11;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

endpackage

// File: rtl/mux_ext_pipe_skid_buffer.sv
// Two-entry valid/ready storage. The output register holds the head beat and
// the skid register catches one extra beat, so in_ready can be a flop.
module skid_buffer
  import mux_ext_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  skid_state_t       state;
  skid_state_t       next_state;
  logic [DATA_W-1:0] skid_data;
  logic              accept;
  logic              xfer;
  logic              load_out;
  logic              load_skid;
  logic              out_from_skid;

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid && out_ready;

  // Next-state and datapath load decisions for the occupancy FSM.
  always_comb begin
    next_state    = state;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          next_state = ONE;
          load_out   = 1'b1;
        end else begin
          next_state = EMPTY;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          next_state = ONE;
          load_out   = 1'b1;
        end else if (accept) begin
          next_state = FULL;
          load_skid  = 1'b1;
        end else if (xfer) begin
          next_state = EMPTY;
        end else begin
          next_state = ONE;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain of the head can happen.
        if (xfer) begin
          next_state    = ONE;
          out_from_skid = 1'b1;
        end else begin
          next_state = FULL;
        end
      end
      default: begin
        next_state = EMPTY;
      end
    endcase
  end

  // State, handshake flags and the two data registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state != FULL);
      out_valid <= (next_state != EMPTY);
      if (load_out) begin
        out_data <= in_data;
      end else if (out_from_skid) begin
        out_data <= skid_data;
      end else begin
        out_data <= out_data;
      end
      if (load_skid) begin
        skid_data <= in_data;
      end else begin
        skid_data <= skid_data;
      end
    end
  end

endmodule

// File: rtl/mux_ext_pipe.sv
// Channel select with per-beat byte/half extension, registered behind a
// lossless valid/ready skid buffer. Out-of-range selects yield zero and
// raise a sticky error flag.
module mux_ext_pipe
  import mux_ext_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int IN_W      = 32,
  parameter int OUT_W     = 32,
  parameter     SIGN_MASK = {NUM_IN{1'b0}},
  parameter int SEL_W     = $clog2(NUM_IN)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_IN*IN_W-1:0] in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [1:0]             in_mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sel_err,
  input  logic                   err_clr
);

  if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
    $error("mux_ext_pipe: NUM_IN must be in 2..16");
  end
  if (IN_W < 16) begin : g_bad_in_w
    $error("mux_ext_pipe: IN_W must be >= 16");
  end
  if (OUT_W < 16) begin : g_bad_out_w
    $error("mux_ext_pipe: OUT_W must be >= 16");
  end
  if ($bits(SIGN_MASK) != NUM_IN) begin : g_bad_mask
    $error("mux_ext_pipe: SIGN_MASK width must equal NUM_IN");
  end
  if (SEL_W != $clog2(NUM_IN)) begin : g_bad_sel_w
    $error("mux_ext_pipe: SEL_W is derived and must not be overridden");
  end

  localparam logic [NUM_IN-1:0] MASK = SIGN_MASK;

  logic [IN_W-1:0]  chan;
  logic             chan_sign;
  logic             sel_ok;
  logic [OUT_W-1:0] native_ext;
  logic [OUT_W-1:0] result;
  logic             accept;

  // One-hot OR mux over the channels; no hit means the select is out of range.
  always_comb begin
    chan      = '0;
    chan_sign = 1'b0;
    sel_ok    = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      chan      = chan | ({IN_W{in_sel == SEL_W'(i)}} & in_data[i*IN_W +: IN_W]);
      chan_sign = chan_sign | ((in_sel == SEL_W'(i)) & MASK[i]);
      sel_ok    = sel_ok | (in_sel == SEL_W'(i));
    end
  end

  if (IN_W >= OUT_W) begin : g_native_trunc
    assign native_ext = chan[OUT_W-1:0];
  end else begin : g_native_ext
    assign native_ext = {{(OUT_W-IN_W){chan_sign & chan[IN_W-1]}}, chan};
  end

  // Apply the requested extension mode to the selected channel.
  always_comb begin
    result = '0;
    if (sel_ok) begin
      case (in_mode)
        MODE_NATIVE: result = native_ext;
        MODE_ZEXT8:  result = {{(OUT_W-8){1'b0}}, chan[7:0]};
        MODE_SEXT8:  result = {{(OUT_W-8){chan[7]}}, chan[7:0]};
        MODE_SEXT16: result = {{(OUT_W-16){chan[15]}}, chan[15:0]};
        default:     result = '0;
      endcase
    end else begin
      result = '0;
    end
  end

  assign accept = in_valid && in_ready;

  // Sticky select-error flag; a new error beats a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_err <= 1'b0;
    end else if (accept && !sel_ok) begin
      sel_err <= 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= sel_err;
    end
  end

  skid_buffer #(
    .DATA_W (OUT_W)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .in_data   (result),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

endmodule

// File: tb/tb_mux_ext_pipe.sv
// Directed bench for mux_ext_pipe: three configurations (default, 16-bit
// channels with a sign mask, three channels) driven from one sequence.
module tb_mux_ext_pipe;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  // dut0: defaults
  logic [127:0] d0_in_data = '0;
  logic [1:0]   d0_in_sel = '0;
  logic [1:0]   d0_in_mode = '0;
  logic         d0_in_valid = 1'b0;
  logic         d0_in_ready;
  logic [31:0]  d0_out_data;
  logic         d0_out_valid;
  logic         d0_out_ready = 1'b0;
  logic         d0_sel_err;
  logic         d0_err_clr = 1'b0;

  // dut1: IN_W=16, SIGN_MASK=4'b0010
  logic [63:0]  d1_in_data = '0;
  logic [1:0]   d1_in_sel = '0;
  logic [1:0]   d1_in_mode = '0;
  logic         d1_in_valid = 1'b0;
  logic         d1_in_ready;
  logic [31:0]  d1_out_data;
  logic         d1_out_valid;
  logic         d1_out_ready = 1'b0;
  logic         d1_sel_err;
  logic         d1_err_clr = 1'b0;

  // dut2: NUM_IN=3
  logic [95:0]  d2_in_data = '0;
  logic [1:0]   d2_in_sel = '0;
  logic [1:0]   d2_in_mode = '0;
  logic         d2_in_valid = 1'b0;
  logic         d2_in_ready;
  logic [31:0]  d2_out_data;
  logic         d2_out_valid;
  logic         d2_out_ready = 1'b0;
  logic         d2_sel_err;
  logic         d2_err_clr = 1'b0;

  mux_ext_pipe u_dut0 (
    .clock(clock), .reset(reset), .in_data(d0_in_data), .in_sel(d0_in_sel),
    .in_mode(d0_in_mode), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
    .out_data(d0_out_data), .out_valid(d0_out_valid), .out_ready(d0_out_ready),
    .sel_err(d0_sel_err), .err_clr(d0_err_clr)
  );

  mux_ext_pipe #(.NUM_IN(4), .IN_W(16), .OUT_W(32), .SIGN_MASK(4'b0010)) u_dut1 (
    .clock(clock), .reset(reset), .in_data(d1_in_data), .in_sel(d1_in_sel),
    .in_mode(d1_in_mode), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .out_data(d1_out_data), .out_valid(d1_out_valid), .out_ready(d1_out_ready),
    .sel_err(d1_sel_err), .err_clr(d1_err_clr)
  );

  mux_ext_pipe #(.NUM_IN(3), .SIGN_MASK(3'b000)) u_dut2 (
    .clock(clock), .reset(reset), .in_data(d2_in_data), .in_sel(d2_in_sel),
    .in_mode(d2_in_mode), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .out_data(d2_out_data), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
    .sel_err(d2_sel_err), .err_clr(d2_err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [1:0]  s_sel  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0]  s_mode [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 2'b01, 2'b10};
  logic [31:0] s_exp  [8] = '{32'h1234_5678, 32'h0000_80F0, 32'hCAFE_B00C, 32'h0001_7F85,
                              32'h0000_5678, 32'hFFFF_FFF0, 32'h0000_000C, 32'hFFFF_FF85};

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", {31'd0, d0_out_valid}, 32'd0);
    check("rst_out_data", d0_out_data, 32'd0);
    check("rst_in_ready", {31'd0, d0_in_ready}, 32'd1);
    check("rst_sel_err", {31'd0, d0_sel_err}, 32'd0);
    reset = 1'b0;

    // Extension modes on channel 1
    d0_in_data   = {32'h0, 32'h0, 32'h0000_80F0, 32'h0};
    d0_in_sel    = 2'd1;
    d0_out_ready = 1'b1;
    d0_in_valid  = 1'b1;
    d0_in_mode   = 2'b10;
    step();
    check("m10_valid", {31'd0, d0_out_valid}, 32'd1);
    check("m10_data", d0_out_data, 32'hFFFF_FFF0);
    d0_in_mode = 2'b11;
    step();
    check("m11_data", d0_out_data, 32'hFFFF_80F0);
    d0_in_mode = 2'b01;
    step();
    check("m01_data", d0_out_data, 32'h0000_00F0);
    d0_in_mode = 2'b00;
    step();
    check("m00_data", d0_out_data, 32'h0000_80F0);
    check("m00_in_ready", {31'd0, d0_in_ready}, 32'd1);
    d0_in_valid = 1'b0;
    step();
    check("drain_valid", {31'd0, d0_out_valid}, 32'd0);

    // Narrow channels with per-channel sign mask
    d1_in_data   = {16'h0, 16'h0, 16'h8001, 16'h8001};
    d1_in_mode   = 2'b00;
    d1_in_sel    = 2'd1;
    d1_out_ready = 1'b1;
    d1_in_valid  = 1'b1;
    step();
    check("mask_sel1", d1_out_data, 32'hFFFF_8001);
    d1_in_sel = 2'd0;
    step();
    check("mask_sel0", d1_out_data, 32'h0000_8001);
    d1_in_valid = 1'b0;

    // Backpressure: A, B, C offered with out_ready low
    d0_out_ready = 1'b0;
    d0_in_sel    = 2'd0;
    d0_in_mode   = 2'b00;
    d0_in_valid  = 1'b1;
    d0_in_data   = {96'h0, 32'd1};
    step();
    check("bp_a_out", d0_out_data, 32'd1);
    check("bp_a_ready", {31'd0, d0_in_ready}, 32'd1);
    d0_in_data = {96'h0, 32'd2};
    step();
    check("bp_b_out", d0_out_data, 32'd1);
    check("bp_b_ready", {31'd0, d0_in_ready}, 32'd0);
    d0_in_data = {96'h0, 32'd3};
    step();
    check("bp_c_held", d0_out_data, 32'd1);
    check("bp_c_ready", {31'd0, d0_in_ready}, 32'd0);
    check("bp_c_valid", {31'd0, d0_out_valid}, 32'd1);
    d0_out_ready = 1'b1;
    step();
    check("bp_out2", d0_out_data, 32'd2);
    check("bp_out2_ready", {31'd0, d0_in_ready}, 32'd1);
    step();
    check("bp_out3", d0_out_data, 32'd3);
    check("bp_out3_valid", {31'd0, d0_out_valid}, 32'd1);
    d0_in_valid = 1'b0;
    step();
    check("bp_empty", {31'd0, d0_out_valid}, 32'd0);

    // Invalid select on the three-channel instance
    d2_in_data   = {32'h0, 32'h0, 32'h0000_0055};
    d2_out_ready = 1'b1;
    d2_in_mode   = 2'b00;
    d2_in_sel    = 2'd3;
    d2_in_valid  = 1'b1;
    step();
    check("bad_sel_data", d2_out_data, 32'd0);
    check("bad_sel_valid", {31'd0, d2_out_valid}, 32'd1);
    check("bad_sel_err", {31'd0, d2_sel_err}, 32'd1);
    d2_in_sel = 2'd0;
    step();
    check("sticky_data", d2_out_data, 32'h0000_0055);
    check("sticky_err", {31'd0, d2_sel_err}, 32'd1);
    d2_in_valid = 1'b0;
    d2_err_clr  = 1'b1;
    step();
    check("clr_err", {31'd0, d2_sel_err}, 32'd0);
    d2_in_sel   = 2'd3;
    d2_in_valid = 1'b1;
    step();
    check("set_wins", {31'd0, d2_sel_err}, 32'd1);
    d2_in_valid = 1'b0;
    d2_err_clr  = 1'b0;
    step();
    check("set_hold", {31'd0, d2_sel_err}, 32'd1);

    // Reset while the skid buffer is full
    d0_out_ready = 1'b0;
    d0_in_valid  = 1'b1;
    d0_in_sel    = 2'd0;
    d0_in_data   = {96'h0, 32'h0000_00AA};
    step();
    d0_in_data = {96'h0, 32'h0000_00BB};
    step();
    check("full_ready", {31'd0, d0_in_ready}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, d0_out_valid}, 32'd0);
    check("mid_rst_data", d0_out_data, 32'd0);
    check("mid_rst_ready", {31'd0, d0_in_ready}, 32'd1);
    reset        = 1'b0;
    d0_in_valid  = 1'b0;
    d0_out_ready = 1'b1;
    step();
    check("post_rst_valid1", {31'd0, d0_out_valid}, 32'd0);
    step();
    check("post_rst_valid2", {31'd0, d0_out_valid}, 32'd0);

    // Continuous streaming
    d0_in_data  = {32'h0001_7F85, 32'hCAFE_B00C, 32'h0000_80F0, 32'h1234_5678};
    d0_in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d0_in_sel  = s_sel[i];
      d0_in_mode = s_mode[i];
      step();
      check($sformatf("stream_data%0d", i), d0_out_data, s_exp[i]);
      check($sformatf("stream_valid%0d", i), {31'd0, d0_out_valid}, 32'd1);
      check($sformatf("stream_ready%0d", i), {31'd0, d0_in_ready}, 32'd1);
    end
    d0_in_valid = 1'b0;
    step();
    check("stream_end", {31'd0, d0_out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_ext_pipe.md
Name: mux_ext_pipe

Overview:
- Parametrised, handshaked successor to the registered datapath select muxes.
- Selects one of NUM_IN equal-width input channels and applies a per-transaction extension mode: native, zero-extend byte, sign-extend byte or sign-extend half.
- Registers the result behind a valid/ready interface. A 2-entry skid buffer keeps in_ready registered and lossless under backpressure.
- Sits between the register files/ALU and the bus/register-load paths that previously used the fixed muxes.

Parameters:
- NUM_IN, 4, number of input channels (2..16)
- IN_W, 32, width of each input channel (>= 16)
- OUT_W, 32, output width (>= 16)
- SIGN_MASK, {NUM_IN{1'b0}}, bit i = 1: channel i is sign-extended in native mode; 0: zero-extended
- SEL_W, $clog2(NUM_IN), select width (derived, not overridden)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_data  in  NUM_IN*IN_W  packed channels; channel i occupies [i*IN_W +: IN_W]
- in_sel  in  SEL_W  channel select, sampled on accept
- in_mode  in  2  extension mode, sampled on accept
- in_valid  in  1  request valid
- in_ready  out  1  block can accept (registered)
- out_data  out  OUT_W  selected, extended result
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts
- sel_err  out  1  sticky: an accepted transaction had in_sel >= NUM_IN
- err_clr  in  1  clears sel_err

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, in_ready=1, sel_err=0, skid entry invalid.
  - Reset mid-operation discards both held entries. No output beat is produced for them.
- Accept: in_valid && in_ready at a rising edge.
- Transfer: out_valid && out_ready at a rising edge.
- Latency: an accepted beat appears on out_data/out_valid the cycle after accept, provided the output stage is empty or transferring that cycle.
- Data computation for channel c = in_data[in_sel*IN_W +: IN_W]:
  - mode 2'b00 native: c resized to OUT_W. If IN_W < OUT_W, sign-extend when SIGN_MASK[in_sel]=1, else zero-extend. If IN_W > OUT_W, truncate to low OUT_W bits.
  - mode 2'b01: zero-extend c[7:0].
  - mode 2'b10: sign-extend c[7:0].
  - mode 2'b11: sign-extend c[15:0].
- Invalid select (in_sel >= NUM_IN, only possible when NUM_IN is not a power of 2):
  - The beat is still accepted, with result 0.
  - sel_err is set on the accept edge.
- sel_err:
  - Cleared by err_clr on a rising edge.
  - If a set event and err_clr occur in the same cycle, set wins.
- Skid buffer states: EMPTY (out_valid=0), ONE (out_valid=1, skid invalid), FULL (out_valid=1, skid valid).
  - EMPTY --accept--> ONE.
  - ONE --accept, no transfer--> FULL.
  - ONE --transfer, no accept--> EMPTY.
  - ONE --accept and transfer--> ONE (new beat replaces output).
  - FULL --transfer--> ONE (skid moves to output; no accept possible).
  - in_ready = !(state == FULL), registered.
- Ordering: beats leave in accept order. No beat is dropped or duplicated.
- out_data is stable while out_valid && !out_ready.
- in_sel, in_mode and in_data are don't-care when no accept occurs.
- Elaboration-time checks: parameter ranges, SIGN_MASK width == NUM_IN.

Decomposition:
- Package mux_ext_pkg holds: ext_mode constants MODE_NATIVE=2'b00, MODE_ZEXT8=2'b01, MODE_SEXT8=2'b10, MODE_SEXT16=2'b11; the skid-state encoding EMPTY/ONE/FULL.
- Sub-module skid_buffer, parameter DATA_W:
  - Handles the valid/ready storage only.
  - Instantiated with DATA_W=OUT_W.
  - Extension/select logic stays combinational in mux_ext_pipe ahead of it.

Test Plan:
1. Defaults (SIGN_MASK=4'b0000); channel1=32'h0000_80F0, sel=1, out_ready=1:
   - mode 10 -> 32'hFFFF_FFF0
   - mode 11 -> 32'hFFFF_80F0
   - mode 01 -> 32'h0000_00F0
   - mode 00 -> 32'h0000_80F0
   - each one cycle after accept.
2. IN_W=16, OUT_W=32, SIGN_MASK=4'b0010; channel1=16'h8001, channel0=16'h8001, mode 00:
   - sel=1 -> 32'hFFFF_8001
   - sel=0 -> 32'h0000_8001
3. Backpressure: out_ready=0, offer beats A=1, B=2, C=3 on consecutive cycles:
   - A held on output, B taken into skid, in_ready=0 from the cycle after B is accepted, C not accepted.
   - Raise out_ready -> outputs 1, 2, 3 in order, each exactly once.
4. NUM_IN=3, sel=3:
   - out_data=0, sel_err=1, and it stays 1 across later valid beats.
   - err_clr pulse -> 0.
   - err_clr in the same cycle as another sel=3 accept -> stays 1.
5. Reset mid-operation with state FULL:
   - Assert reset between edges -> immediately out_valid=0, out_data=0, in_ready=1.
   - After release, no stale beat appears.
6. Continuous streaming with out_ready=1 and in_valid=1 for 8 cycles, sel cycling 0..3:
   - One result per cycle, in_ready never drops, results match the reference model.
